// File: rtl/sfifo_level_pkg.sv
// Shared types for the single-clock level-tracking FIFO.
package sfifo_level_pkg;

  // Per-cycle operation mix, encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/sfifo_level_mem.sv
// Storage array: synchronous write, asynchronous read. Contents are never reset.
module sfifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Store the word at the write address on an accepted write.
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/sfifo_level.sv
// Single-clock FIFO with registered fill level, almost-full/empty thresholds,
// optional first-word-fall-through read and sticky overflow/underflow flags.
module sfifo_level
  import sfifo_level_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 2 ** ASIZE - 2,
  parameter int AE_THRESH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [DSIZE-1:0] i_wdata,
  output logic             o_wfull,
  output logic             o_afull,
  input  logic             i_rd,
  output logic [DSIZE-1:0] o_rdata,
  output logic             o_rempty,
  output logic             o_aempty,
  output logic [ASIZE:0]   o_level,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  localparam int DEPTH = 2 ** ASIZE;
  localparam int LW    = ASIZE + 1;

  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] AF_T    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_T    = LW'(AE_THRESH);

  // Out-of-range parameters stop elaboration.
  if (DSIZE < 1) begin : g_bad_dsize
    $error("sfifo_level: DSIZE must be >= 1");
  end
  if (ASIZE < 1 || ASIZE > 8) begin : g_bad_asize
    $error("sfifo_level: ASIZE must be in 1..8");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sfifo_level: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sfifo_level: AE_THRESH out of range");
  end

  logic [LW-1:0]    wptr_q, wptr_d;
  logic [LW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             wfull_d, rempty_d;
  logic             ovf_q, unf_q;
  logic             wr_acc, rd_acc;
  logic [DSIZE-1:0] mem_rdata;
  op_e              op;

  // Acceptance is judged on the registered flags; nothing is accepted during reset.
  assign wr_acc = i_wr && !wfull_q && !i_rst;
  assign rd_acc = i_rd && !rempty_q && !i_rst;
  assign op     = op_e'({wr_acc, rd_acc});

  // Next-state pointers, level and full/empty, so flags land on the same edge as the level.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_acc) wptr_d = wptr_q + LVL_ONE;
    if (rd_acc) rptr_d = rptr_q + LVL_ONE;
    case (op)
      OP_WR:   level_d = level_q + LVL_ONE;
      OP_RD:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
               (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    rempty_d = (wptr_d == rptr_d);
  end

  // Pointer, level and status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= (level_d >= AF_T);
      aempty_q <= (level_d <= AE_T);
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_wr && wfull_q)  ovf_q <= 1'b1;
      else if (i_clr_err)   ovf_q <= 1'b0;
      if (i_rd && rempty_q) unf_q <= 1'b1;
      else if (i_clr_err)   unf_q <= 1'b0;
    end
  end

  sfifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_acc),
    .i_waddr (wptr_q[ASIZE-1:0]),
    .i_wdata (i_wdata),
    .i_raddr (rptr_q[ASIZE-1:0]),
    .o_rdata (mem_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DSIZE-1:0] rdata_q;

    // Registered read: capture the head word when a read is accepted, hold otherwise.
    always_ff @(posedge i_clk) begin
      if (i_rst)       rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem_rdata;
    end

    assign o_rdata = rdata_q;
  end else begin : g_fwft
    assign o_rdata = mem_rdata;
  end

  assign o_level     = level_q;
  assign o_wfull     = wfull_q;
  assign o_rempty    = rempty_q;
  assign o_afull     = afull_q;
  assign o_aempty    = aempty_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_sfifo_level.sv
// Bench for sfifo_level: a queue scoreboard against a standard-mode instance,
// plus directed checks on a first-word-fall-through instance.
module tb_sfifo_level;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance.
  logic       rst, wr, rd, clr;
  logic [7:0] wdata, rdata;
  logic       wfull, afull, rempty, aempty, ovf, unf;
  logic [4:0] level;

  sfifo_level #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_wdata(wdata), .o_wfull(wfull),
    .o_afull(afull), .i_rd(rd), .o_rdata(rdata), .o_rempty(rempty),
    .o_aempty(aempty), .o_level(level), .o_overflow(ovf), .o_underflow(unf),
    .i_clr_err(clr)
  );

  // FWFT instance.
  logic       f_rst, f_wr, f_rd, f_clr;
  logic [7:0] f_wdata, f_rdata;
  logic       f_wfull, f_afull, f_rempty, f_aempty, f_ovf, f_unf;
  logic [4:0] f_level;

  sfifo_level #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) dut_fwft (
    .i_clk(clk), .i_rst(f_rst), .i_wr(f_wr), .i_wdata(f_wdata), .o_wfull(f_wfull),
    .o_afull(f_afull), .i_rd(f_rd), .o_rdata(f_rdata), .o_rempty(f_rempty),
    .o_aempty(f_aempty), .o_level(f_level), .o_overflow(f_ovf), .o_underflow(f_unf),
    .i_clr_err(f_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard and reference state for the standard-mode instance.
  logic [7:0] sb_q[$];
  int         m_lvl;
  logic       m_ovf, m_unf;
  logic [7:0] m_rdata;

  // One clock of stimulus, then update the reference and compare every output.
  task automatic step(input logic s_wr, input logic [7:0] s_wd, input logic s_rd,
                      input logic s_clr, input logic s_rst);
    logic wa, ra;
    wr = s_wr; wdata = s_wd; rd = s_rd; clr = s_clr; rst = s_rst;
    @(posedge clk);
    #1;
    if (s_rst) begin
      sb_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_rdata = 8'h00;
    end else begin
      wa = s_wr && (m_lvl != 16);
      ra = s_rd && (m_lvl != 0);
      if (s_wr && m_lvl == 16) m_ovf = 1'b1;
      else if (s_clr)          m_ovf = 1'b0;
      if (s_rd && m_lvl == 0)  m_unf = 1'b1;
      else if (s_clr)          m_unf = 1'b0;
      if (ra) m_rdata = sb_q.pop_front();
      if (wa) sb_q.push_back(s_wd);
    end
    m_lvl = sb_q.size();
    chk("level",     32'(level),  32'(m_lvl));
    chk("wfull",     32'(wfull),  32'(m_lvl == 16));
    chk("rempty",    32'(rempty), 32'(m_lvl == 0));
    chk("afull",     32'(afull),  32'(m_lvl >= 14));
    chk("aempty",    32'(aempty), 32'(m_lvl <= 2));
    chk("overflow",  32'(ovf),    32'(m_ovf));
    chk("underflow", 32'(unf),    32'(m_unf));
    chk("rdata",     32'(rdata),  32'(m_rdata));
    wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic f_step(input logic s_wr, input logic [7:0] s_wd, input logic s_rd,
                        input logic s_rst);
    f_wr = s_wr; f_wdata = s_wd; f_rd = s_rd; f_rst = s_rst; f_clr = 1'b0;
    @(posedge clk);
    #1;
    f_wr = 1'b0; f_rd = 1'b0; f_rst = 1'b0;
  endtask

  initial begin
    wr = 0; rd = 0; clr = 0; rst = 1; wdata = 0;
    f_wr = 0; f_rd = 0; f_clr = 0; f_rst = 1; f_wdata = 0;
    m_lvl = 0; m_ovf = 0; m_unf = 0; m_rdata = 0;

    // Reset values.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Fill with 0x00..0x0F; thresholds are checked on every edge.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_flag",  32'(wfull), 32'd1);

    // Overflow, then overflow coinciding with clear: flag must stay set.
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hAB, 0, 1, 0);
    chk("ovf_set_wins", 32'(ovf), 32'd1);

    // Drain; scoreboard checks 0x00..0x0F in order and that 0xAA never appears.
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    chk("drain_empty", 32'(rempty), 32'd1);

    // Underflow, then a clear on its own.
    step(0, 8'h00, 1, 0, 0);
    chk("unf_set", 32'(unf), 32'd1);
    step(0, 8'h00, 0, 1, 0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_unf", 32'(unf), 32'd0);

    // Simultaneous read/write at level 5.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    chk("rw_level5", 32'(level), 32'd5);

    // Simultaneous read/write at full: only the read is taken.
    for (int i = 0; i < 11; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    chk("rw_full_level", 32'(level), 32'd15);

    // Drain, then simultaneous read/write at empty: only the write is taken.
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    chk("rw_empty_level", 32'(level), 32'd1);
    chk("rw_empty_unf",   32'(unf),   32'd1);

    // Reset mid-stream at level 7 with a write pending.
    for (int i = 0; i < 6; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    chk("pre_rst_level", 32'(level), 32'd7);
    step(1, 8'hDD, 0, 0, 1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_unf",   32'(unf),   32'd0);
    step(1, 8'h77, 0, 0, 0);
    step(1, 8'h78, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("first_after_rst", 32'(rdata), 32'h77);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 0);

    // FWFT instance.
    f_step(0, 8'h00, 0, 1);
    chk("fwft_rst_empty", 32'(f_rempty), 32'd1);
    f_step(1, 8'h5A, 0, 0);
    chk("fwft_empty_after_wr", 32'(f_rempty), 32'd0);
    chk("fwft_head",           32'(f_rdata),  32'h5A);
    f_step(1, 8'h5B, 0, 0);
    chk("fwft_head_hold",      32'(f_rdata),  32'h5A);
    chk("fwft_level2",         32'(f_level),  32'd2);
    f_step(0, 8'h00, 1, 0);
    chk("fwft_pop",            32'(f_rdata),  32'h5B);
    chk("fwft_level1",         32'(f_level),  32'd1);
    f_step(0, 8'h00, 1, 0);
    chk("fwft_drained",        32'(f_rempty), 32'd1);
    f_step(0, 8'h00, 1, 0);
    chk("fwft_unf",            32'(f_unf),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
